tage_table_ctrl: RTL and testbench
==================================

// Module: tage_table_ctrl
// PURPOSE
//  Sequencer for one TAGE tagged-component table. Shares the table's single index port between
//  the prediction lookup requester and the branch-resolution update requester. Converts each
//  update into a read-evaluate-write sequence: counter/useful update on tag hit, allocation on miss.
//  Runs a periodic useful-bit aging sweep. Sits between the predictor top level and the table.
// PARAMETERS
//  IL         10    table index width (2**IL entries)
//  TAG_LEN    8     tag width
//  UL         2     useful-counter width
//  CL         3     prediction-counter width
//  AGE_PERIOD 256   accepted updates between aging sweeps (>=1)
//  STARVE_MAX 4     max consecutive lookup grants while an update waits
// PORTS
//  Clk            in   1        clock
//  reset          in   1        synchronous, active-low reset
//  lk_valid       in   1        lookup request
//  lk_ready       out  1        lookup accepted when lk_valid&&lk_ready
//  lk_index       in   IL       lookup index
//  lk_rsp_valid   out  1        lookup response strobe, 1 cycle
//  lk_rsp_tag     out  TAG_LEN  tag read
//  lk_rsp_u       out  UL       useful bits read
//  lk_rsp_c       out  CL       counter read
//  up_valid       in   1        update request
//  up_ready       out  1        update accepted when up_valid&&up_ready
//  up_index       in   IL       update index
//  up_tag         in   TAG_LEN  tag computed for resolved branch
//  up_taken       in   1        resolved direction
//  up_mispred     in   1        final prediction was wrong
//  busy           out  1        FSM not in IDLE
//  tbl_rd         out  1        to table rd
//  tbl_index      out  IL       to table index
//  tbl_wdata_tag  out  TAG_LEN  to table wdata_tag_bits
//  tbl_inc_u / tbl_dec_u  out 1 to table useful inc/dec
//  tbl_inc_c / tbl_dec_c  out 1 to table counter inc/dec
//  tbl_alloc      out  1        to table alloc
//  tbl_upd_en     out  1        to table update_enable
//  tbl_rtag / tbl_ru / tbl_rc  in  TAG_LEN/UL/CL  table registered read data
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, age counter=0, starve counter=0, sweep pointer=0.
//    All outputs 0 except lk_ready=up_ready=1 on the first cycle after reset. Reset aborts any
//    sequence or sweep mid-flight. No partial write is issued.
//  - tbl_* are decoded from state plus registered request fields. Outside an active step they
//    are 0. tbl_upd_en is 1 only in UP_WR and AGE.
//  - States: IDLE, LK_RD, LK_RSP, UP_RD, UP_EV, UP_WR, AGE.
//  - IDLE: lk_ready=up_ready=1 only here, and only if no sweep is pending. Grant priority:
//    pending sweep > lookup > update.
//    Exception: update wins when up_valid and starve==STARVE_MAX.
//    starve increments on each lookup grant while up_valid=1, saturates, and clears on an
//    update grant. When both are valid, only the winner's ready is 1.
//  - Lookup path:
//    LK_RD: tbl_rd=1 at latched index.
//    LK_RSP: tbl_rd=1 held; lk_rsp_valid=1 with lk_rsp_* = tbl_r*. Then IDLE.
//    Accept to response is 2 cycles; one lookup per 3 cycles max.
//  - Update path:
//    UP_RD: tbl_rd=1.
//    UP_EV: tbl_rd=1; data valid; decision registered. hit = (tbl_rtag==up_tag).
//    UP_WR: one cycle, tbl_upd_en=1, then IDLE.
//      hit: tbl_inc_c=up_taken, tbl_dec_c=!up_taken; tbl_inc_u=!up_mispred, tbl_dec_u=up_mispred.
//      miss & mispred & tbl_ru==0: tbl_alloc=1, tbl_dec_u=1, tbl_wdata_tag=up_tag (tag replaced).
//      miss & mispred & tbl_ru!=0: tbl_dec_u=1 only (age victim).
//      miss & !mispred: no strobes (upd_en still 1, table unchanged).
//    Saturation is enforced by the table; the controller never suppresses strobes for it.
//  - Aging:
//    age counter increments per accepted update. On reaching AGE_PERIOD it wraps to 0 and sets
//    sweep_pending.
//    AGE: one entry per cycle, tbl_index=ptr, tbl_dec_u=1, tbl_upd_en=1, alloc=0.
//    ptr runs 0..2**IL-1, then wraps to 0 and returns to IDLE. Duration is 2**IL cycles.
//    An update accepted in the same cycle the counter wraps still completes first.
//  - Simultaneous lk_valid/up_valid with sweep pending: neither is accepted.
// STRUCTURE
//  - Shared package tage_pkg: state enum encoding (3 bits), default widths IL/TAG_LEN/UL/CL.
//  - Sub-module tage_age_timer: age counter plus sweep pointer; outputs sweep_pending and
//    ptr_last. Everything else stays in one always block (FSM) plus one decode block.
// TESTING (bench IL=4, AGE_PERIOD=4, STARVE_MAX=2, real table instance)
//  1 lookup idx 3 after reset: lk_rsp_valid exactly 2 cycles after accept, tag=0,u=0,c=0.
//  2 update idx 5, tag 0x3C, mispred, u=0: after 4 cycles idx 5 tag=0x3C.
//    A second identical update with taken=1, mispred=0 gives c=1, u=1.
//  3 lookup and update held valid continuously: update granted on every 3rd grant
//    (2 lookups, 1 update); no starvation.
//  4 4th accepted update triggers sweep: busy for 16 cycles, ready=0 throughout.
//    Afterwards every entry's u is reduced by 1 (floor 0).
//  5 reset asserted in UP_EV and mid-sweep: next cycle state IDLE, no table field changes,
//    all outputs 0.
//  6 update miss, mispred, u=2: tag unchanged, u becomes 1; a miss with !mispred leaves the
//    entry identical.

Source files
------------

// File: rtl/tage_pkg.sv
// ----------------------------------------------------------------------------
// tage_pkg
// Shared definitions for the TAGE tagged-table sequencer.
//   - default table geometry (index, tag, useful and counter widths)
//   - controller state encoding (3 bits)
//   - per-update write decision and the function that derives it
// ----------------------------------------------------------------------------
package tage_pkg;

  localparam int IL_DEF      = 10;
  localparam int TAG_LEN_DEF = 8;
  localparam int UL_DEF      = 2;
  localparam int CL_DEF      = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LK_RD  = 3'd1,
    ST_LK_RSP = 3'd2,
    ST_UP_RD  = 3'd3,
    ST_UP_EV  = 3'd4,
    ST_UP_WR  = 3'd5,
    ST_AGE    = 3'd6
  } tage_state_t;

  // Strobes issued to the table in the single write cycle of an update.
  typedef struct packed {
    logic inc_c;
    logic dec_c;
    logic inc_u;
    logic dec_u;
    logic alloc;
  } tage_upd_t;

  // Hit: train counter toward the outcome, reward or punish usefulness.
  // Miss on a misprediction: claim the entry if nobody finds it useful,
  // otherwise only age the current owner so it can be claimed later.
  // Miss on a correct prediction: leave the entry alone.
  function automatic tage_upd_t tage_decide(input logic hit,
                                            input logic taken,
                                            input logic mispred,
                                            input logic u_zero);
    tage_upd_t d;
    d = '0;
    if (hit) begin
      d.inc_c = taken;
      d.dec_c = !taken;
      d.inc_u = !mispred;
      d.dec_u = mispred;
    end else if (mispred) begin
      d.dec_u = 1'b1;
      d.alloc = u_zero;
    end else begin
      d = '0;
    end
    return d;
  endfunction

endpackage

// File: rtl/tage_age_timer.sv
// ----------------------------------------------------------------------------
// tage_age_timer
// Counts accepted updates and runs the useful-bit aging sweep pointer.
// Ports:
//   Clk, reset      clock, synchronous active-low reset
//   upd_accept      one accepted update this cycle
//   sweep_step      controller is in the aging state; advance the pointer
//   sweep_pending   a sweep is due or in progress
//   ptr             entry being aged this cycle
//   ptr_last        ptr is at the last table entry
// ----------------------------------------------------------------------------
module tage_age_timer #(
  parameter int IL         = 10,
  parameter int AGE_PERIOD = 256
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic          upd_accept,
  input  logic          sweep_step,
  output logic          sweep_pending,
  output logic [IL-1:0] ptr,
  output logic          ptr_last
);

  localparam int            AW       = $clog2(AGE_PERIOD) + 1;
  localparam logic [AW-1:0] AGE_LAST = AW'(AGE_PERIOD - 1);

  logic [AW-1:0] age_cnt;

  // Update counter wraps at the period and arms a sweep; the sweep pointer
  // walks the whole table once and disarms the sweep on its last entry.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      age_cnt       <= '0;
      sweep_pending <= 1'b0;
      ptr           <= '0;
    end else begin
      if (upd_accept) begin
        if (age_cnt == AGE_LAST) begin
          age_cnt       <= '0;
          sweep_pending <= 1'b1;
        end else begin
          age_cnt <= age_cnt + AW'(1'b1);
        end
      end
      if (sweep_step) begin
        ptr <= ptr + IL'(1'b1);
        if (ptr_last) begin
          sweep_pending <= 1'b0;
        end
      end
    end
  end

  assign ptr_last = (ptr == {IL{1'b1}});

endmodule

// File: rtl/tage_table_ctrl.sv
// ----------------------------------------------------------------------------
// tage_table_ctrl
// Sequencer for one TAGE tagged-component table. Arbitrates the table's
// single index port between lookups and updates, turns each update into a
// read / evaluate / write sequence and runs the periodic aging sweep.
// Ports:
//   Clk, reset                   clock, synchronous active-low reset
//   lk_valid/lk_ready/lk_index   lookup request handshake
//   lk_rsp_valid, lk_rsp_*       lookup response (one-cycle strobe)
//   up_valid/up_ready/up_*       update request handshake and payload
//   busy                         controller not idle
//   tbl_*  (out)                 table command: rd, index, tag data, strobes
//   tbl_rtag/tbl_ru/tbl_rc (in)  table registered read data
// ----------------------------------------------------------------------------
module tage_table_ctrl
  import tage_pkg::*;
#(
  parameter int IL         = IL_DEF,
  parameter int TAG_LEN    = TAG_LEN_DEF,
  parameter int UL         = UL_DEF,
  parameter int CL         = CL_DEF,
  parameter int AGE_PERIOD = 256,
  parameter int STARVE_MAX = 4
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               lk_valid,
  output logic               lk_ready,
  input  logic [IL-1:0]      lk_index,
  output logic               lk_rsp_valid,
  output logic [TAG_LEN-1:0] lk_rsp_tag,
  output logic [UL-1:0]      lk_rsp_u,
  output logic [CL-1:0]      lk_rsp_c,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [IL-1:0]      up_index,
  input  logic [TAG_LEN-1:0] up_tag,
  input  logic               up_taken,
  input  logic               up_mispred,
  output logic               busy,
  output logic               tbl_rd,
  output logic [IL-1:0]      tbl_index,
  output logic [TAG_LEN-1:0] tbl_wdata_tag,
  output logic               tbl_inc_u,
  output logic               tbl_dec_u,
  output logic               tbl_inc_c,
  output logic               tbl_dec_c,
  output logic               tbl_alloc,
  output logic               tbl_upd_en,
  input  logic [TAG_LEN-1:0] tbl_rtag,
  input  logic [UL-1:0]      tbl_ru,
  input  logic [CL-1:0]      tbl_rc
);

  localparam int            SW         = $clog2(STARVE_MAX + 2);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  tage_state_t        state;
  tage_state_t        state_nxt;
  logic [IL-1:0]      req_index;
  logic [TAG_LEN-1:0] req_tag;
  logic               req_taken;
  logic               req_mispred;
  tage_upd_t          decision;
  logic [SW-1:0]      starve;

  logic               starve_full;
  logic               lk_grant;
  logic               up_grant;
  logic               sweep_step;
  logic               sweep_pending;
  logic               ptr_last;
  logic [IL-1:0]      sweep_ptr;

  assign starve_full = (starve == STARVE_TOP);
  assign lk_grant    = lk_valid && lk_ready;
  assign up_grant    = up_valid && up_ready;
  assign sweep_step  = (state == ST_AGE);

  tage_age_timer #(
    .IL         (IL),
    .AGE_PERIOD (AGE_PERIOD)
  ) u_age_timer (
    .Clk           (Clk),
    .reset         (reset),
    .upd_accept    (up_grant),
    .sweep_step    (sweep_step),
    .sweep_pending (sweep_pending),
    .ptr           (sweep_ptr),
    .ptr_last      (ptr_last)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request capture, starvation tracking and the registered update decision.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      req_index   <= '0;
      req_tag     <= '0;
      req_taken   <= 1'b0;
      req_mispred <= 1'b0;
      decision    <= '0;
      starve      <= '0;
    end else begin
      if (lk_grant) begin
        req_index <= lk_index;
      end else if (up_grant) begin
        req_index   <= up_index;
        req_tag     <= up_tag;
        req_taken   <= up_taken;
        req_mispred <= up_mispred;
      end
      // Lookups granted over a waiting update count toward forcing it through.
      if (up_grant) begin
        starve <= '0;
      end else if (lk_grant && up_valid && !starve_full) begin
        starve <= starve + SW'(1'b1);
      end
      // Read data of the entry is valid in UP_EV; freeze the verdict here.
      if (state == ST_UP_EV) begin
        decision <= tage_decide(tbl_rtag == req_tag, req_taken, req_mispred,
                                tbl_ru == '0);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (sweep_pending) begin
          state_nxt = ST_AGE;
        end else if (lk_grant) begin
          state_nxt = ST_LK_RD;
        end else if (up_grant) begin
          state_nxt = ST_UP_RD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_LK_RD:  state_nxt = ST_LK_RSP;
      ST_LK_RSP: state_nxt = ST_IDLE;
      ST_UP_RD:  state_nxt = ST_UP_EV;
      ST_UP_EV:  state_nxt = ST_UP_WR;
      ST_UP_WR:  state_nxt = ST_IDLE;
      ST_AGE: begin
        if (ptr_last) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_AGE;
        end
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output decode. Everything is held at 0 while reset is applied so a
  // sequence or sweep cut short by reset never issues a partial write.
  always_comb begin
    lk_ready      = 1'b0;
    up_ready      = 1'b0;
    lk_rsp_valid  = 1'b0;
    lk_rsp_tag    = '0;
    lk_rsp_u      = '0;
    lk_rsp_c      = '0;
    busy          = 1'b0;
    tbl_rd        = 1'b0;
    tbl_index     = '0;
    tbl_wdata_tag = '0;
    tbl_inc_u     = 1'b0;
    tbl_dec_u     = 1'b0;
    tbl_inc_c     = 1'b0;
    tbl_dec_c     = 1'b0;
    tbl_alloc     = 1'b0;
    tbl_upd_en    = 1'b0;
    if (!reset) begin
      busy = 1'b0;
    end else begin
      busy = (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          // Lookup wins a tie unless the update has waited long enough.
          if (!sweep_pending) begin
            lk_ready = !(up_valid && starve_full);
            up_ready = !(lk_valid && !starve_full);
          end else begin
            lk_ready = 1'b0;
            up_ready = 1'b0;
          end
        end
        ST_LK_RD: begin
          tbl_rd    = 1'b1;
          tbl_index = req_index;
        end
        ST_LK_RSP: begin
          tbl_rd       = 1'b1;
          tbl_index    = req_index;
          lk_rsp_valid = 1'b1;
          lk_rsp_tag   = tbl_rtag;
          lk_rsp_u     = tbl_ru;
          lk_rsp_c     = tbl_rc;
        end
        ST_UP_RD, ST_UP_EV: begin
          tbl_rd    = 1'b1;
          tbl_index = req_index;
        end
        ST_UP_WR: begin
          tbl_index     = req_index;
          tbl_upd_en    = 1'b1;
          tbl_inc_c     = decision.inc_c;
          tbl_dec_c     = decision.dec_c;
          tbl_inc_u     = decision.inc_u;
          tbl_dec_u     = decision.dec_u;
          tbl_alloc     = decision.alloc;
          tbl_wdata_tag = decision.alloc ? req_tag : '0;
        end
        ST_AGE: begin
          tbl_index  = sweep_ptr;
          tbl_dec_u  = 1'b1;
          tbl_upd_en = 1'b1;
        end
        default: begin
          tbl_rd = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tage_table_ctrl.sv
// ----------------------------------------------------------------------------
// tb_tage_table_ctrl
// Drives tage_table_ctrl attached to a small behavioural table and compares
// lookup responses, handshakes and table contents with a transaction-level
// model of the TAGE update and aging rules.
// ----------------------------------------------------------------------------
module tb_tage_table_ctrl;

  localparam int IL = 4, TL = 8, UL = 2, CL = 3, AP = 4, SM = 2;
  localparam int N  = 16;

  logic          Clk = 1'b0;
  logic          reset = 1'b0;
  logic          lk_valid = 1'b0;
  logic          lk_ready;
  logic [IL-1:0] lk_index = '0;
  logic          lk_rsp_valid;
  logic [TL-1:0] lk_rsp_tag;
  logic [UL-1:0] lk_rsp_u;
  logic [CL-1:0] lk_rsp_c;
  logic          up_valid = 1'b0;
  logic          up_ready;
  logic [IL-1:0] up_index = '0;
  logic [TL-1:0] up_tag = '0;
  logic          up_taken = 1'b0;
  logic          up_mispred = 1'b0;
  logic          busy, tbl_rd, tbl_inc_u, tbl_dec_u, tbl_inc_c, tbl_dec_c;
  logic          tbl_alloc, tbl_upd_en;
  logic [IL-1:0] tbl_index;
  logic [TL-1:0] tbl_wdata_tag;
  logic [TL-1:0] tbl_rtag = '0;
  logic [UL-1:0] tbl_ru = '0;
  logic [CL-1:0] tbl_rc = '0;

  // Table storage, starts cleared.
  logic [TL-1:0] t_tag [N] = '{default: '0};
  logic [UL-1:0] t_u   [N] = '{default: '0};
  logic [CL-1:0] t_c   [N] = '{default: '0};

  // Reference model state.
  int m_tag [N];
  int m_u   [N];
  int m_c   [N];
  int m_age;
  int m_starve;
  int n_chk = 0;
  int n_err = 0;

  tage_table_ctrl #(
    .IL(IL), .TAG_LEN(TL), .UL(UL), .CL(CL), .AGE_PERIOD(AP), .STARVE_MAX(SM)
  ) dut (
    .Clk(Clk), .reset(reset),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_index(lk_index),
    .lk_rsp_valid(lk_rsp_valid), .lk_rsp_tag(lk_rsp_tag),
    .lk_rsp_u(lk_rsp_u), .lk_rsp_c(lk_rsp_c),
    .up_valid(up_valid), .up_ready(up_ready), .up_index(up_index),
    .up_tag(up_tag), .up_taken(up_taken), .up_mispred(up_mispred),
    .busy(busy), .tbl_rd(tbl_rd), .tbl_index(tbl_index),
    .tbl_wdata_tag(tbl_wdata_tag), .tbl_inc_u(tbl_inc_u), .tbl_dec_u(tbl_dec_u),
    .tbl_inc_c(tbl_inc_c), .tbl_dec_c(tbl_dec_c), .tbl_alloc(tbl_alloc),
    .tbl_upd_en(tbl_upd_en), .tbl_rtag(tbl_rtag), .tbl_ru(tbl_ru), .tbl_rc(tbl_rc)
  );

  always #5 Clk = ~Clk;

  // Table: registered read, saturating counters, tag write on allocation.
  always @(posedge Clk) begin
    if (tbl_rd) begin
      tbl_rtag <= t_tag[tbl_index];
      tbl_ru   <= t_u[tbl_index];
      tbl_rc   <= t_c[tbl_index];
    end
    if (tbl_upd_en) begin
      if (tbl_alloc) t_tag[tbl_index] <= tbl_wdata_tag;
      if (tbl_inc_u && t_u[tbl_index] != 2'd3) t_u[tbl_index] <= t_u[tbl_index] + 2'd1;
      else if (tbl_dec_u && t_u[tbl_index] != 2'd0) t_u[tbl_index] <= t_u[tbl_index] - 2'd1;
      if (tbl_inc_c && t_c[tbl_index] != 3'd7) t_c[tbl_index] <= t_c[tbl_index] + 3'd1;
      else if (tbl_dec_c && t_c[tbl_index] != 3'd0) t_c[tbl_index] <= t_c[tbl_index] - 3'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Applies one resolved branch to the model; returns 1 when it completes an aging period.
  function automatic bit model_update(input int idx, input int tag, input bit taken, input bit misp);
    if (m_tag[idx] == tag) begin
      if (taken) m_c[idx] = (m_c[idx] < 7) ? m_c[idx] + 1 : 7;
      else       m_c[idx] = (m_c[idx] > 0) ? m_c[idx] - 1 : 0;
      if (misp)  m_u[idx] = (m_u[idx] > 0) ? m_u[idx] - 1 : 0;
      else       m_u[idx] = (m_u[idx] < 3) ? m_u[idx] + 1 : 3;
    end else if (misp) begin
      if (m_u[idx] == 0) m_tag[idx] = tag;
      else               m_u[idx] = m_u[idx] - 1;
    end
    m_age++;
    if (m_age == AP) begin
      m_age = 0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void model_sweep(input int upto);
    for (int i = 0; i < upto; i++) m_u[i] = (m_u[i] > 0) ? m_u[i] - 1 : 0;
  endfunction

  // All tasks start and end just after a falling edge with the controller idle.
  task automatic do_lookup(input int idx);
    lk_index = idx[IL-1:0];
    lk_valid = 1'b1;
    #1;
    check("lk_ready", lk_ready, 1);
    @(negedge Clk);
    lk_valid = 1'b0;
    check("lk_rsp_early", lk_rsp_valid, 0);
    @(negedge Clk);
    check("lk_rsp_valid", lk_rsp_valid, 1);
    check("lk_rsp_tag", lk_rsp_tag, m_tag[idx]);
    check("lk_rsp_u", lk_rsp_u, m_u[idx]);
    check("lk_rsp_c", lk_rsp_c, m_c[idx]);
    @(negedge Clk);
    check("lk_rsp_done", lk_rsp_valid, 0);
  endtask

  // abort_at >= 0: if this update starts a sweep, reset after that many sweep steps.
  task automatic do_update(input int idx, input int tag, input bit taken, input bit misp,
                           input int abort_at);
    bit   sweep;
    int   n;
    logic rdy;
    up_index   = idx[IL-1:0];
    up_tag     = tag[TL-1:0];
    up_taken   = taken;
    up_mispred = misp;
    up_valid   = 1'b1;
    #1;
    check("up_ready", up_ready, 1);
    @(negedge Clk);
    up_valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("up_wr_en", tbl_upd_en, 1);
    @(negedge Clk);
    check("up_done_busy", busy, 0);
    sweep = model_update(idx, tag, taken, misp);
    if (sweep) begin
      lk_valid = 1'b1;
      up_valid = 1'b1;
      #1;
      check("pend_ready", {lk_ready, up_ready}, 0);
      @(negedge Clk);
      lk_valid = 1'b0;
      up_valid = 1'b0;
      if (abort_at >= 0) begin
        repeat (abort_at) @(negedge Clk);
        reset = 1'b0;
        model_sweep(abort_at);
        m_age = 0;
        @(negedge Clk);
        check("abort_busy", busy, 0);
        check("abort_upd_en", tbl_upd_en, 0);
        check("abort_dec_u", tbl_dec_u, 0);
        reset = 1'b1;
        @(negedge Clk);
        check("abort_ready", {lk_ready, up_ready}, 2'b11);
      end else begin
        n   = 0;
        rdy = 1'b0;
        while (busy && n < 40) begin
          n++;
          rdy = rdy | lk_ready | up_ready;
          @(negedge Clk);
        end
        check("sweep_len", n, N);
        check("sweep_ready", rdy, 0);
        model_sweep(N);
      end
    end
  endtask

  initial begin
    bit want_up, sw;
    int li, ui, ut, n_up;
    bit utk, ump;
    for (int i = 0; i < N; i++) begin
      m_tag[i] = 0; m_u[i] = 0; m_c[i] = 0;
    end
    m_age = 0;
    m_starve = 0;

    // Reset state.
    repeat (2) @(negedge Clk);
    check("rst_busy", busy, 0);
    check("rst_ready_held", {lk_ready, up_ready}, 0);
    reset = 1'b1;
    @(negedge Clk);
    check("rst_ready", {lk_ready, up_ready}, 2'b11);
    check("rst_outs", {busy, tbl_rd, tbl_upd_en, tbl_alloc, tbl_dec_u, lk_rsp_valid}, 0);
    check("rst_index", tbl_index, 0);

    // Lookup of a never-written entry.
    do_lookup(3);

    // Allocate on miss, then train on hit.
    do_update(5, 8'h3C, 1'b0, 1'b1, -1);
    check("alloc_tag", t_tag[5], 8'h3C);
    do_lookup(5);
    do_update(5, 8'h3C, 1'b1, 1'b0, -1);
    do_lookup(5);
    check("hit_c", t_c[5], 1);
    check("hit_u", t_u[5], 1);

    // Fourth update launches the sweep.
    do_update(5, 8'h3C, 1'b1, 1'b0, -1);
    do_update(7, 8'h55, 1'b0, 1'b1, -1);
    for (int i = 0; i < N; i++) do_lookup(i);

    // Miss with u!=0 ages the owner; miss without mispredict leaves it alone.
    do_update(5, 8'h3C, 1'b1, 1'b0, -1);
    do_update(5, 8'h11, 1'b0, 1'b1, -1);
    do_lookup(5);
    check("victim_tag", t_tag[5], 8'h3C);
    do_update(5, 8'h22, 1'b1, 1'b0, -1);
    do_lookup(5);

    // Random traffic.
    for (int k = 0; k < 40; k++) begin
      li = $urandom_range(0, N - 1);
      if ($urandom_range(0, 2) == 0) begin
        do_lookup(li);
      end else begin
        ut = ($urandom_range(0, 1) == 1) ? m_tag[li] : $urandom_range(0, 255);
        do_update(li, ut, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
      end
    end

    // Reset while the update is evaluating: no write, back to idle.
    ui = 9;
    up_index = ui[IL-1:0]; up_tag = 8'hA5; up_taken = 1'b1; up_mispred = 1'b1;
    up_valid = 1'b1;
    #1;
    check("ev_up_ready", up_ready, 1);
    @(negedge Clk);
    up_valid = 1'b0;
    @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    check("ev_abort_busy", busy, 0);
    check("ev_abort_outs", {tbl_rd, tbl_upd_en, tbl_alloc, tbl_dec_u, tbl_inc_u}, 0);
    reset = 1'b1;
    m_age = 0;
    m_starve = 0;
    @(negedge Clk);
    check("ev_abort_ready", {lk_ready, up_ready}, 2'b11);
    do_lookup(ui);

    // Both requesters held valid: two lookups then one update, repeating.
    n_up = 0;
    lk_valid = 1'b1;
    up_valid = 1'b1;
    for (int g = 0; g < 6; g++) begin
      li  = $urandom_range(0, N - 1);
      ui  = $urandom_range(0, N - 1);
      ut  = ($urandom_range(0, 1) == 1) ? m_tag[ui] : $urandom_range(0, 255);
      utk = 1'($urandom_range(0, 1));
      ump = 1'($urandom_range(0, 1));
      lk_index = li[IL-1:0]; up_index = ui[IL-1:0]; up_tag = ut[TL-1:0];
      up_taken = utk; up_mispred = ump;
      #1;
      want_up = (m_starve == SM);
      check("ctn_lk_ready", lk_ready, !want_up);
      check("ctn_up_ready", up_ready, want_up);
      @(negedge Clk);
      if (want_up) begin
        m_starve = 0;
        n_up++;
        repeat (3) @(negedge Clk);
        sw = model_update(ui, ut, utk, ump);
        check("ctn_no_sweep", sw, 0);
      end else begin
        m_starve = (m_starve < SM) ? m_starve + 1 : SM;
        @(negedge Clk);
        check("ctn_rsp_valid", lk_rsp_valid, 1);
        check("ctn_rsp_tag", lk_rsp_tag, m_tag[li]);
        check("ctn_rsp_u", lk_rsp_u, m_u[li]);
        check("ctn_rsp_c", lk_rsp_c, m_c[li]);
        @(negedge Clk);
      end
    end
    lk_valid = 1'b0;
    up_valid = 1'b0;
    check("ctn_updates", n_up, 2);

    // Sweep cut short by reset after five entries.
    do_update(2, m_tag[2], 1'b1, 1'b0, -1);
    do_update(11, 8'h77, 1'b0, 1'b1, 5);
    for (int i = 0; i < N; i++) do_lookup(i);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
